load_store_unit: RTL
====================

# load_store_unit

Memory-stage load/store unit fed directly by the execute-stage ALU: takes the ALU result as the effective address, performs one RV32I load or store per request against a data memory port with a valid/ack handshake, and returns load data aligned and sign- or zero-extended for write-back. It holds the pipeline through `busy` while a memory access is outstanding, so data-memory latency is not fixed.

## Interface
- `DATA_WIDTH`, 32, data and address width; only 32 is supported.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present from execute stage.
- `req_ready`  out  1  unit can accept a request this cycle.
- `mem_write`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RV32I width/sign code.
- `addr`  in  DATA_WIDTH  effective address (ALU result).
- `wdata`  in  DATA_WIDTH  store data (rs2), low bits significant.
- `resp_valid`  out  1  one-cycle pulse: access finished.
- `rdata`  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- `err`  out  1  qualified by `resp_valid`: misaligned or illegal `funct3`.
- `busy`  out  1  request accepted and response not yet given.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  memory write enable.
- `dmem_addr`  out  DATA_WIDTH  word address, `addr` with bits [1:0] = 0.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  DATA_WIDTH  lane-replicated store data.
- `dmem_ack`  in  1  memory completed the request (carries read data).
- `dmem_rdata`  in  DATA_WIDTH  read word, valid with `dmem_ack`.

## Operation
- States: IDLE, BUS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch `mem_write`, `funct3`, `addr`, `wdata`. If legal and aligned → BUS, else → RESP with `err`=1 and no memory access.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Anything else is illegal.
- Alignment: halfword needs `addr[0]`=0; word needs `addr[1:0]`=0; bytes are always aligned.
- BUS: `dmem_req`=1 with stable `dmem_addr`, `dmem_we`, `dmem_be`, `dmem_wdata` until `dmem_ack`. On ack, capture extended load data → RESP.
- Byte enables: SB `4'b0001 << addr[1:0]`; SH `4'b0011 << addr[1:0]`; SW `4'b1111`. Loads drive `dmem_be`=1111.
- Store data: SB replicates the byte four times; SH replicates the halfword twice; SW passes data unchanged.
- Load extraction: take the lane selected by `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- RESP: `resp_valid`=1 for exactly one cycle, then → IDLE. `rdata` and `err` hold their value until the next RESP.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `err`=0, `rdata`=0, `busy`=0, `dmem_req`=0, `dmem_we`=0, `dmem_be`=0, `dmem_addr`=0, `dmem_wdata`=0.
- Normal access latency: accept at cycle T, `dmem_req` high from T+1. With ack at T+1+k, `resp_valid` pulses at T+2+k. Minimum is 2 cycles.
- Error latency: `resp_valid` at T+1 and `dmem_req` never asserts.
- No back-to-back accepts: the next accept is possible at the RESP+1 cycle.
- `dmem_ack` outside BUS is ignored. Request inputs outside IDLE are ignored.
- Reset mid-access (BUS or RESP): return to IDLE on that edge, drop `dmem_req`, produce no `resp_valid`. Any late ack is ignored.
- `dmem_*` outputs are registered, with no combinational path from `req_*` inputs.

## Structure
- Package `lsu_pkg`:
  - `funct3` localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum `lsu_state_t`.
  - Function for byte-enable generation.
- Sub-module `lsu_align`: purely combinational.
  - Inputs: `funct3`, `addr[1:0]`, `wdata`, `dmem_rdata`.
  - Outputs: `be`, replicated write data, extended load data, `misaligned`, `illegal`.
- Top level holds only the FSM and registers.

## Test plan
- LW at 0x100, ack after 3 wait cycles, `dmem_rdata`=0xDEADBEEF → `dmem_addr`=0x100, `be`=1111, `resp_valid` 5 cycles after accept, `rdata`=0xDEADBEEF, `err`=0.
- LB at 0x203 with `dmem_rdata`=0x80FF7F01 → `rdata`=0xFFFFFF80. LBU same → 0x00000080. LH at 0x202 → 0xFFFF80FF. LHU at 0x202 → 0x000080FF.
- SB at 0x101, `wdata`=0x123456AB → `dmem_addr`=0x100, `be`=0010, `dmem_wdata`=0xABABABAB, `we`=1. SH at 0x102, `wdata`=0x0000BEEF → `be`=1100, `dmem_wdata`=0xBEEFBEEF.
- LW at 0x102, SH at 0x101, or `funct3`=011 → no `dmem_req`, `resp_valid` at T+1, `err`=1, `rdata`=0.
- Assert `reset` during BUS, then ack one cycle later → no `resp_valid`, `dmem_req`=0, `req_ready`=1 after the reset edge.
- `req_valid` held high across two requests with zero-wait ack → second accept only in the cycle after the first `resp_valid`; `busy` low only in that cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
package lsu_pkg;
  localparam int LSU_DW = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUS, RESP} lsu_state_t;

  // Only what is still needed after accept; address/data go straight to dmem regs.
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] ofs;
  } lsu_req_t;

  function automatic logic [3:0] gen_be(input logic we, input logic [2:0] f3,
                                        input logic [1:0] ofs);
    if (!we) return 4'b1111;
    case (f3)
      F3_B:    return 4'b0001 << ofs;
      F3_H:    return 4'b0011 << ofs;
      default: return 4'b1111;
    endcase
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
interface load_store_unit_if #(parameter int DATA_WIDTH = 32);
  logic                  req_valid;
  logic                  req_ready;
  logic                  mem_write;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;
  logic                  busy;
  logic                  dmem_req;
  logic                  dmem_we;
  logic [DATA_WIDTH-1:0] dmem_addr;
  logic [3:0]            dmem_be;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_ack;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  modport master (
    output req_valid, mem_write, funct3, addr, wdata, dmem_ack, dmem_rdata,
    input  req_ready, resp_valid, rdata, err, busy,
           dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );

  modport slave (
    input  req_valid, mem_write, funct3, addr, wdata, dmem_ack, dmem_rdata,
    output req_ready, resp_valid, rdata, err, busy,
           dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extract/extend, legality.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  ofs,
  input  logic [31:0] wdata,
  input  logic [31:0] dmem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        illegal
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = dmem_rdata[{ofs, 3'b000} +: 8];
  assign lane_h = ofs[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign be     = gen_be(mem_write, funct3, ofs);

  always_comb begin
    rdata_ext = dmem_rdata;
    case (funct3)
      F3_B:    rdata_ext = {{24{lane_b[7]}}, lane_b};
      F3_H:    rdata_ext = {{16{lane_h[15]}}, lane_h};
      F3_BU:   rdata_ext = {24'b0, lane_b};
      F3_HU:   rdata_ext = {16'b0, lane_h};
      default: ;
    endcase
  end

  always_comb begin
    wdata_rep = wdata;
    case (funct3)
      F3_B:    wdata_rep = {4{wdata[7:0]}};
      F3_H:    wdata_rep = {2{wdata[15:0]}};
      default: ;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (funct3)
      F3_H, F3_HU: misaligned = ofs[0];
      F3_W:        misaligned = |ofs;
      default:     ;
    endcase
  end

  assign illegal = mem_write ? !(funct3 inside {F3_B, F3_H, F3_W})
                             : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage LSU: one RV32I load/store per request over a valid/ack data port.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);
  lsu_state_t state_q, state_d;
  lsu_req_t   req_q;

  logic                  dmem_req_q, dmem_we_q, err_q;
  logic [3:0]            dmem_be_q;
  logic [DATA_WIDTH-1:0] dmem_addr_q, dmem_wdata_q, rdata_q;

  logic        idle, bad;
  logic        al_we, al_mis, al_ill;
  logic [2:0]  al_f3;
  logic [1:0]  al_ofs;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  assign idle = (state_q == IDLE);

  // Align logic sees the incoming request while idle and the latched one afterwards.
  assign al_we  = idle ? bus.mem_write : req_q.we;
  assign al_f3  = idle ? bus.funct3    : req_q.funct3;
  assign al_ofs = idle ? bus.addr[1:0] : req_q.ofs;
  assign bad    = al_mis | al_ill;

  lsu_align u_align (
    .mem_write  (al_we),
    .funct3     (al_f3),
    .ofs        (al_ofs),
    .wdata      (bus.wdata),
    .dmem_rdata (bus.dmem_rdata),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_mis),
    .illegal    (al_ill)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = bad ? RESP : BUS;
      BUS:     if (bus.dmem_ack)  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q        <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_be_q    <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          req_q <= '{we: bus.mem_write, funct3: bus.funct3, ofs: bus.addr[1:0]};
          if (bad) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= bus.mem_write;
            dmem_be_q    <= al_be;
            dmem_addr_q  <= {bus.addr[DATA_WIDTH-1:2], 2'b00};
            dmem_wdata_q <= al_wdata;
          end
        end
        BUS: if (bus.dmem_ack) begin
          dmem_req_q <= 1'b0;
          err_q      <= 1'b0;
          rdata_q    <= req_q.we ? '0 : al_rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = idle;
  assign bus.busy       = !idle;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.rdata      = rdata_q;
  assign bus.err        = err_q;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_be    = dmem_be_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
endmodule
